// File: rtl/arf_tagged.sv
// arf_tagged: architected register file with per-register busy/ROB-tag rename state, tag-checked commit, flush and commit bypass
module arf_tagged #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int TAG_W = 6,
    parameter int NREAD = 2,
    localparam int RA_W  = $clog2(NREG),
    localparam int CNT_W = $clog2(NREG + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREAD*RA_W-1:0]  rd_addr,
    output logic [NREAD*XLEN-1:0]  rd_data,
    output logic [NREAD-1:0]       rd_busy,
    output logic [NREAD*TAG_W-1:0] rd_tag,
    input  logic                   dp_valid,
    input  logic [RA_W-1:0]        dp_dest,
    input  logic [TAG_W-1:0]       dp_tag,
    input  logic                   cm_valid,
    input  logic [RA_W-1:0]        cm_reg,
    input  logic [TAG_W-1:0]       cm_tag,
    input  logic [XLEN-1:0]        cm_data,
    input  logic                   flush,
    output logic [CNT_W-1:0]       busy_cnt
);
    logic [XLEN-1:0]  data     [NREG];
    logic [TAG_W-1:0] tag      [NREG];
    logic [TAG_W-1:0] tag_nxt  [NREG];
    logic [NREG-1:0]  busy, busy_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    // Commit clears are evaluated first so a same-cycle dispatch overrides them.
    always_comb begin
        busy_nxt = busy;
        tag_nxt  = tag;
        cnt_nxt  = '0;
        for (int r = 1; r < NREG; r++) begin
            if (flush) begin
                busy_nxt[r] = 1'b0;
                tag_nxt[r]  = '0;
            end else begin
                if (cm_valid && cm_reg == RA_W'(r) && busy[r] && tag[r] == cm_tag)
                    busy_nxt[r] = 1'b0;
                if (dp_valid && dp_dest == RA_W'(r)) begin
                    busy_nxt[r] = 1'b1;
                    tag_nxt[r]  = dp_tag;
                end
            end
            cnt_nxt = cnt_nxt + CNT_W'(busy_nxt[r]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                data[r] <= '0;
                tag[r]  <= '0;
            end
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            if (cm_valid && cm_reg != '0)
                data[cm_reg] <= cm_data;
            busy     <= busy_nxt;
            tag      <= tag_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    for (genvar g = 0; g < NREAD; g++) begin : g_rd
        logic [RA_W-1:0] a;
        assign a = rd_addr[g*RA_W +: RA_W];
        assign rd_data[g*XLEN +: XLEN] = (a == '0) ? '0 : (cm_valid && cm_reg == a) ? cm_data : data[a];
        assign rd_busy[g] = (a == '0) ? 1'b0 : busy[a];
        assign rd_tag[g*TAG_W +: TAG_W] = (a == '0) ? '0 : tag[a];
    end
endmodule

// File: tb/tb_arf_tagged.sv
// tb_arf_tagged: directed vector table on the default configuration plus a random model comparison on a 64-entry, 4-port instance
module tb_arf_tagged;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // ---------------- default configuration: NREG=32, NREAD=2 ----------------
    logic        rst_a = 1'b1;
    logic [9:0]  ra_a = '0;
    logic [63:0] rdd_a;
    logic [1:0]  rb_a;
    logic [11:0] rt_a;
    logic        dv_a = 0, cv_a = 0, fl_a = 0;
    logic [4:0]  dd_a = 0, cr_a = 0;
    logic [5:0]  dt_a = 0, ct_a = 0;
    logic [31:0] cd_a = 0;
    logic [5:0]  cnt_a;

    arf_tagged dut_a (
        .clk(clk), .reset(rst_a), .rd_addr(ra_a), .rd_data(rdd_a), .rd_busy(rb_a), .rd_tag(rt_a),
        .dp_valid(dv_a), .dp_dest(dd_a), .dp_tag(dt_a),
        .cm_valid(cv_a), .cm_reg(cr_a), .cm_tag(ct_a), .cm_data(cd_a),
        .flush(fl_a), .busy_cnt(cnt_a)
    );

    // ---------------- wide configuration: NREG=64, NREAD=4 ----------------
    logic         rst_b = 1'b1;
    logic [23:0]  ra_b = '0;
    logic [127:0] rdd_b;
    logic [3:0]   rb_b;
    logic [23:0]  rt_b;
    logic         dv_b = 0, cv_b = 0, fl_b = 0;
    logic [5:0]   dd_b = 0, cr_b = 0;
    logic [5:0]   dt_b = 0, ct_b = 0;
    logic [31:0]  cd_b = 0;
    logic [6:0]   cnt_b;

    arf_tagged #(.XLEN(32), .NREG(64), .TAG_W(6), .NREAD(4)) dut_b (
        .clk(clk), .reset(rst_b), .rd_addr(ra_b), .rd_data(rdd_b), .rd_busy(rb_b), .rd_tag(rt_b),
        .dp_valid(dv_b), .dp_dest(dd_b), .dp_tag(dt_b),
        .cm_valid(cv_b), .cm_reg(cr_b), .cm_tag(ct_b), .cm_data(cd_b),
        .flush(fl_b), .busy_cnt(cnt_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic        dv;
        logic [4:0]  dd;
        logic [5:0]  dt;
        logic        cv;
        logic [4:0]  cr;
        logic [5:0]  ct;
        logic [31:0] cd;
        logic        fl;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] d0;
        logic        b0;
        logic [5:0]  t0;
        logic [31:0] d1;
        logic        b1;
        logic [5:0]  t1;
        logic [5:0]  cnt;
    } vec_t;

    task automatic drive_a(input logic dv, input logic [4:0] dd, input logic [5:0] dt,
                           input logic cv, input logic [4:0] cr, input logic [5:0] ct,
                           input logic [31:0] cd, input logic fl, input logic [4:0] a0, input logic [4:0] a1);
        @(negedge clk);
        dv_a = dv; dd_a = dd; dt_a = dt;
        cv_a = cv; cr_a = cr; ct_a = ct; cd_a = cd;
        fl_a = fl; ra_a = {a1, a0};
        #1;
    endtask

    task automatic check_a(input string name, input logic [31:0] d0, input logic b0, input logic [5:0] t0,
                           input logic [31:0] d1, input logic b1, input logic [5:0] t1, input logic [5:0] cnt);
        chk({name, ".d0"}, rdd_a[31:0], d0);
        chk({name, ".b0"}, 32'(rb_a[0]), 32'(b0));
        chk({name, ".t0"}, 32'(rt_a[5:0]), 32'(t0));
        chk({name, ".d1"}, rdd_a[63:32], d1);
        chk({name, ".b1"}, 32'(rb_a[1]), 32'(b1));
        chk({name, ".t1"}, 32'(rt_a[11:6]), 32'(t1));
        chk({name, ".cnt"}, 32'(cnt_a), 32'(cnt));
    endtask

    // reference model for the wide instance
    logic [31:0] m_data [64];
    logic [63:0] m_busy;
    logic [5:0]  m_tag  [64];
    int          m_cnt;

    task automatic model_reset();
        for (int r = 0; r < 64; r++) begin
            m_data[r] = 0;
            m_tag[r] = 0;
        end
        m_busy = 0;
        m_cnt = 0;
    endtask

    vec_t vecs [16];

    initial begin
        // dv dd dt  cv cr ct cd  fl a0 a1  d0 b0 t0  d1 b1 t1  cnt
        vecs[0]  = '{0,0,0,  0,0,0,0,            0,0,31, 0,0,0,           0,0,0,           0};
        vecs[1]  = '{0,0,0,  1,0,0,32'hDEAD,     0,0,5,  0,0,0,           0,0,0,           0};
        vecs[2]  = '{1,5,12, 0,0,0,0,            0,5,0,  0,0,0,           0,0,0,           0};
        vecs[3]  = '{0,0,0,  1,5,12,32'h1234,    0,5,5,  32'h1234,1,12,   32'h1234,1,12,   1};
        vecs[4]  = '{0,0,0,  0,0,0,0,            0,5,0,  32'h1234,0,12,   0,0,0,           0};
        vecs[5]  = '{1,7,3,  0,0,0,0,            0,7,0,  0,0,0,           0,0,0,           0};
        vecs[6]  = '{1,7,9,  0,0,0,0,            0,7,0,  0,1,3,           0,0,0,           1};
        vecs[7]  = '{0,0,0,  1,7,3,32'hAA,       0,7,0,  32'hAA,1,9,      0,0,0,           1};
        vecs[8]  = '{0,0,0,  0,0,0,0,            0,7,5,  32'hAA,1,9,      32'h1234,0,12,   1};
        vecs[9]  = '{0,0,0,  1,7,9,32'hBB,       0,7,0,  32'hBB,1,9,      0,0,0,           1};
        vecs[10] = '{0,0,0,  0,0,0,0,            0,7,0,  32'hBB,0,9,      0,0,0,           0};
        vecs[11] = '{1,4,20, 0,0,0,0,            0,4,0,  0,0,0,           0,0,0,           0};
        vecs[12] = '{1,4,20, 1,4,20,32'h55,      0,4,0,  32'h55,1,20,     0,0,0,           1};
        vecs[13] = '{0,0,0,  0,0,0,0,            0,4,0,  32'h55,1,20,     0,0,0,           1};
        vecs[14] = '{0,0,0,  1,6,0,32'h66,       0,6,0,  32'h66,0,0,      0,0,0,           1};
        vecs[15] = '{0,0,0,  0,0,0,0,            0,6,4,  32'h66,0,0,      32'h55,1,20,     1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_a = 0;
        rst_b = 0;

        for (int r = 0; r < 32; r += 2) begin
            drive_a(0,0,0, 0,0,0,0, 0, 5'(r), 5'(r + 1));
            check_a($sformatf("rst_r%0d", r), 0,0,0, 0,0,0, 0);
        end

        for (int i = 0; i < 16; i++) begin
            drive_a(vecs[i].dv, vecs[i].dd, vecs[i].dt, vecs[i].cv, vecs[i].cr, vecs[i].ct,
                    vecs[i].cd, vecs[i].fl, vecs[i].a0, vecs[i].a1);
            check_a($sformatf("vec%0d", i), vecs[i].d0, vecs[i].b0, vecs[i].t0,
                    vecs[i].d1, vecs[i].b1, vecs[i].t1, vecs[i].cnt);
        end

        // rename r1..r10 (r4 already busy), then flush with a commit to r2 and a dispatch to r11
        for (int r = 1; r <= 10; r++)
            drive_a(1, 5'(r), 6'(r), 0,0,0,0, 0, 0, 0);
        drive_a(1, 11, 33, 1, 2, 0, 32'h77, 1, 3, 2);
        check_a("flush_cyc", 0,1,3, 32'h77,1,2, 10);
        drive_a(0,0,0, 0,0,0,0, 0, 2, 11);
        check_a("flush_r2_r11", 32'h77,0,0, 0,0,0, 0);
        drive_a(0,0,0, 0,0,0,0, 0, 5, 7);
        check_a("flush_r5_r7", 32'h1234,0,0, 32'hBB,0,0, 0);
        drive_a(0,0,0, 0,0,0,0, 0, 4, 6);
        check_a("flush_r4_r6", 32'h55,0,0, 32'h66,0,0, 0);

        // reset mid-operation discards the same-cycle dispatch and commit
        drive_a(1, 8, 5, 0,0,0,0, 0, 0, 0);
        drive_a(1, 3, 7, 1, 3, 0, 32'h99, 0, 8, 0);
        check_a("pre_rst", 0,1,5, 0,0,0, 1);
        rst_a = 1;
        drive_a(0,0,0, 0,0,0,0, 0, 3, 8);
        rst_a = 0;
        check_a("rst_mid", 0,0,0, 0,0,0, 0);
        drive_a(0,0,0, 0,0,0,0, 0, 5, 2);
        check_a("rst_mid_data", 0,0,0, 0,0,0, 0);

        // random run on the wide instance against the model
        model_reset();
        for (int it = 0; it < 10000; it++) begin
            int base;
            logic [31:0] exp_d;
            logic        r_rst;
            @(negedge clk);
            r_rst = ($urandom_range(0, 199) == 0);
            rst_b = r_rst;
            dv_b = $urandom_range(0, 1);
            dd_b = 6'($urandom_range(0, 63));
            dt_b = 6'($urandom_range(0, 3));
            cv_b = $urandom_range(0, 1);
            cr_b = ($urandom_range(0, 3) == 0) ? dd_b : 6'($urandom_range(0, 63));
            ct_b = 6'($urandom_range(0, 3));
            cd_b = $urandom;
            fl_b = ($urandom_range(0, 49) == 0);
            base = $urandom_range(0, 63);
            for (int p = 0; p < 4; p++)
                ra_b[p*6 +: 6] = 6'((base + p * 17) % 64);
            if ($urandom_range(0, 7) == 0)
                cr_b = ra_b[5:0];
            #1;
            for (int p = 0; p < 4; p++) begin
                int a;
                a = int'(ra_b[p*6 +: 6]);
                exp_d = (cv_b && int'(cr_b) == a && a != 0) ? cd_b : m_data[a];
                chk($sformatf("rnd%0d.p%0d.data", it, p), rdd_b[p*32 +: 32], exp_d);
                chk($sformatf("rnd%0d.p%0d.busy", it, p), 32'(rb_b[p]), 32'(m_busy[a]));
                chk($sformatf("rnd%0d.p%0d.tag", it, p), 32'(rt_b[p*6 +: 6]), 32'(m_tag[a]));
            end
            chk($sformatf("rnd%0d.cnt", it), 32'(cnt_b), 32'(m_cnt));
            if (r_rst) begin
                model_reset();
            end else begin
                if (cv_b && cr_b != 0) begin
                    m_data[cr_b] = cd_b;
                    if (m_busy[cr_b] && m_tag[cr_b] == ct_b)
                        m_busy[cr_b] = 1'b0;
                end
                if (fl_b) begin
                    m_busy = 0;
                    for (int r = 0; r < 64; r++)
                        m_tag[r] = 0;
                end else if (dv_b && dd_b != 0) begin
                    m_busy[dd_b] = 1'b1;
                    m_tag[dd_b] = dt_b;
                end
                m_cnt = $countones(m_busy);
            end
        end
        @(negedge clk);
        rst_b = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
